pe_dot_accum: RTL and testbench

- Downstream compute stage of the per-PE weight circular buffer.
- Each accepted cycle it takes one broadcast activation x[k] and the 8 row weights w_r[k] the buffer presents, and runs 8 parallel signed Q8.8 multiply-accumulates.
- Every 8 accepted inputs it rounds and saturates the 8 dot products and offers them with a valid/ready handshake.
- It drives the buffer's read enable, so buffer column pointer and block element counter advance in lockstep.

---
 rtl/pe_pkg.sv | 38 +++
 rtl/pe_mac_lane.sv | 45 ++++
 rtl/pe_dot_accum.sv | 124 ++++++++++++
 tb/tb_pe_dot_accum.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE dot-product stage.
// The state encoding, the lane geometry and the Q-format round/saturate function.
package pe_pkg;

   localparam int DATA_W = 16;
   localparam int LANES  = 8;
   localparam int FRAC   = 8;
   localparam int ACC_W  = 40;
   localparam int PROD_W = 2 * DATA_W;
   localparam int EXT_W  = 64;

   localparam logic signed [EXT_W-1:0] SAT_MAX = 64'sd32767;
   localparam logic signed [EXT_W-1:0] SAT_MIN = -64'sd32768;

   typedef enum logic [2:0] {
      IDLE,
      ACCUM,
      FLUSH,
      ROUND,
      HOLD
   } state_t;

   // The caller widens acc to EXT_W, so the rounding add never overflows.
   function automatic logic signed [DATA_W-1:0] sat_round(
      input logic signed [EXT_W-1:0] acc,
      input int                      frac
   );
      logic signed [EXT_W-1:0] half;
      logic signed [EXT_W-1:0] r;
      half = '0;
      if (frac > 0) half[frac-1] = 1'b1;
      r = (acc + half) >>> frac;
      if (r > SAT_MAX)      return 16'sh7FFF;
      else if (r < SAT_MIN) return 16'sh8000;
      else                  return $signed(r[DATA_W-1:0]);
   endfunction

endpackage

// File: rtl/pe_mac_lane.sv
// One row of the dot-product engine: product register, accumulator and
// rounded/saturated result register, all driven by control from the parent.
module pe_mac_lane #(
   parameter int FRAC  = pe_pkg::FRAC,
   parameter int ACC_W = pe_pkg::ACC_W,
   parameter int RELU  = 0
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic signed [pe_pkg::DATA_W-1:0]  w,
   input  logic signed [pe_pkg::DATA_W-1:0]  x,
   input  logic                              load,
   input  logic                              prod_vld,
   input  logic                              prod_first,
   input  logic                              round_en,
   output logic        [pe_pkg::DATA_W-1:0]  result
);
   import pe_pkg::*;

   logic signed [PROD_W-1:0] prod_reg;
   logic signed [ACC_W-1:0]  acc_reg;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [DATA_W-1:0] rounded;
   logic signed [PROD_W-1:0] w_ext;
   logic signed [PROD_W-1:0] x_ext;

   assign w_ext    = $signed({{DATA_W{w[DATA_W-1]}}, w});
   assign x_ext    = $signed({{DATA_W{x[DATA_W-1]}}, x});
   assign prod_ext = ACC_W'(prod_reg);
   assign rounded  = sat_round(EXT_W'(acc_reg), FRAC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_reg <= '0;
         acc_reg  <= '0;
         result   <= '0;
      end else begin
         if (load) prod_reg <= w_ext * x_ext;
         // First product of a block overwrites, so no clear cycle is needed.
         if (prod_vld) acc_reg <= prod_first ? prod_ext : acc_reg + prod_ext;
         if (round_en) result <= (RELU != 0 && rounded[DATA_W-1]) ? '0 : rounded;
      end
   end

endmodule

// File: rtl/pe_dot_accum.sv
// 8-row signed Q8.8 dot-product stage fed by the per-PE weight circular buffer.
// Accepts 8 activations per block, then offers the rounded results until taken.
module pe_dot_accum #(
   parameter int FRAC  = pe_pkg::FRAC,
   parameter int ACC_W = pe_pkg::ACC_W,
   parameter int RELU  = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] w_0,
   input  logic [15:0] w_1,
   input  logic [15:0] w_2,
   input  logic [15:0] w_3,
   input  logic [15:0] w_4,
   input  logic [15:0] w_5,
   input  logic [15:0] w_6,
   input  logic [15:0] w_7,
   input  logic [15:0] x_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        buf_read_en,
   output logic [15:0] out_data_0,
   output logic [15:0] out_data_1,
   output logic [15:0] out_data_2,
   output logic [15:0] out_data_3,
   output logic [15:0] out_data_4,
   output logic [15:0] out_data_5,
   output logic [15:0] out_data_6,
   output logic [15:0] out_data_7,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy
);
   import pe_pkg::*;

   state_t      state_reg, state_next;
   logic [2:0]  k_reg;
   logic        prod_vld_reg;
   logic        prod_first_reg;
   logic        accept;
   logic        round_en;

   logic [DATA_W-1:0] w_arr   [LANES];
   logic [DATA_W-1:0] res_arr [LANES];

   assign w_arr[0] = w_0;
   assign w_arr[1] = w_1;
   assign w_arr[2] = w_2;
   assign w_arr[3] = w_3;
   assign w_arr[4] = w_4;
   assign w_arr[5] = w_5;
   assign w_arr[6] = w_6;
   assign w_arr[7] = w_7;

   assign out_data_0 = res_arr[0];
   assign out_data_1 = res_arr[1];
   assign out_data_2 = res_arr[2];
   assign out_data_3 = res_arr[3];
   assign out_data_4 = res_arr[4];
   assign out_data_5 = res_arr[5];
   assign out_data_6 = res_arr[6];
   assign out_data_7 = res_arr[7];

   assign accept      = in_valid & in_ready;
   assign buf_read_en = accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         k_reg          <= '0;
         prod_vld_reg   <= 1'b0;
         prod_first_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         prod_vld_reg   <= accept;
         prod_first_reg <= accept && (k_reg == 3'd0);
         if (accept) k_reg <= k_reg + 3'd1;
      end
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      round_en   = 1'b0;
      busy       = (state_reg != IDLE);
      case (state_reg)
         IDLE:  state_next = ACCUM;
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && k_reg == 3'd7) state_next = FLUSH;
         end
         FLUSH: state_next = ROUND;
         ROUND: begin
            round_en   = 1'b1;
            state_next = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_next = ACCUM;
         end
         default: state_next = IDLE;
      endcase
   end

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      pe_mac_lane #(
         .FRAC  (FRAC),
         .ACC_W (ACC_W),
         .RELU  (RELU)
      ) u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .w          (w_arr[gi]),
         .x          (x_in),
         .load       (accept),
         .prod_vld   (prod_vld_reg),
         .prod_first (prod_first_reg),
         .round_en   (round_en),
         .result     (res_arr[gi])
      );
   end

endmodule

// File: tb/tb_pe_dot_accum.sv
// Directed scoreboard bench for pe_dot_accum: a RELU=0 and a RELU=1 instance
// share all stimulus; expected rows are pushed per block and popped on output.
module tb_pe_dot_accum;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] wv [8];
   logic [15:0] x_in;
   logic        in_valid;
   logic        out_ready;

   logic        in_ready, buf_read_en, out_valid, busy;
   logic [15:0] od0 [8];
   logic        in_ready_r, buf_read_en_r, out_valid_r, busy_r;
   logic [15:0] od1 [8];

   always #5 clk = ~clk;

   pe_dot_accum #(.RELU(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .w_0(wv[0]), .w_1(wv[1]), .w_2(wv[2]), .w_3(wv[3]),
      .w_4(wv[4]), .w_5(wv[5]), .w_6(wv[6]), .w_7(wv[7]),
      .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready), .buf_read_en(buf_read_en),
      .out_data_0(od0[0]), .out_data_1(od0[1]), .out_data_2(od0[2]), .out_data_3(od0[3]),
      .out_data_4(od0[4]), .out_data_5(od0[5]), .out_data_6(od0[6]), .out_data_7(od0[7]),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
   );

   pe_dot_accum #(.RELU(1)) dut_relu (
      .clk(clk), .rst_n(rst_n),
      .w_0(wv[0]), .w_1(wv[1]), .w_2(wv[2]), .w_3(wv[3]),
      .w_4(wv[4]), .w_5(wv[5]), .w_6(wv[6]), .w_7(wv[7]),
      .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready_r), .buf_read_en(buf_read_en_r),
      .out_data_0(od1[0]), .out_data_1(od1[1]), .out_data_2(od1[2]), .out_data_3(od1[3]),
      .out_data_4(od1[4]), .out_data_5(od1[5]), .out_data_6(od1[6]), .out_data_7(od1[7]),
      .out_valid(out_valid_r), .out_ready(out_ready), .busy(busy_r)
   );

   typedef struct packed {
      logic [127:0] e0;
      logic [127:0] e1;
   } exp_t;

   exp_t        sb [$];
   logic [15:0] sw [8][8];
   logic [15:0] sx [8];
   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          rd_cnt   = 0;
   int          rd_base  = 0;
   int          last_e   = 0;
   int          n_txn    = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (buf_read_en) rd_cnt <= rd_cnt + 1;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] pack_rows(input bit relu);
      logic [127:0] p;
      for (int r = 0; r < 8; r++) p[r*16 +: 16] = relu ? od1[r] : od0[r];
      return p;
   endfunction

   function automatic logic [15:0] model(input int row, input bit relu);
      longint acc;
      logic [15:0] res;
      acc = 0;
      for (int b = 0; b < 8; b++)
         acc += longint'($signed(sw[b][row])) * longint'($signed(sx[b]));
      acc = (acc + 128) >>> 8;
      if (acc > 32767)  acc = 32767;
      if (acc < -32768) acc = -32768;
      if (relu && acc < 0) acc = 0;
      res = acc[15:0];
      return res;
   endfunction

   task automatic fill_const(input logic [15:0] w, input logic [15:0] x);
      for (int b = 0; b < 8; b++) begin
         sx[b] = x;
         for (int r = 0; r < 8; r++) sw[b][r] = w;
      end
   endtask

   task automatic fill_rand();
      for (int b = 0; b < 8; b++) begin
         sx[b] = 16'($urandom_range(0, 2047)) - 16'd1024;
         for (int r = 0; r < 8; r++) sw[b][r] = 16'($urandom_range(0, 2047)) - 16'd1024;
      end
   endtask

   task automatic send_block(input bit gaps, input int nbeats);
      exp_t e;
      int   t;
      rd_base = rd_cnt;
      @(posedge clk); #1;
      for (int b = 0; b < nbeats; b++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
               in_valid = 1'b0;
               @(posedge clk); #1;
            end
         end
         for (int r = 0; r < 8; r++) wv[r] = sw[b][r];
         x_in     = sx[b];
         in_valid = 1'b1;
         t = 0;
         while (in_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
         end
         if (t >= 50) chk("in_ready_timeout", 128'(in_ready), 128'd1);
         @(posedge clk); #1;
         last_e = cyc;
      end
      in_valid = 1'b0;
      if (nbeats == 8) begin
         for (int r = 0; r < 8; r++) begin
            e.e0[r*16 +: 16] = model(r, 1'b0);
            e.e1[r*16 +: 16] = model(r, 1'b1);
         end
         sb.push_back(e);
      end
   endtask

   task automatic recv(input int hold);
      exp_t         e;
      logic [127:0] snap0, snap1;
      int           t;
      t = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && t < 30) begin
         @(negedge clk);
         t++;
      end
      chk("out_valid_seen", 128'(out_valid), 128'd1);
      chk("out_valid_relu_seen", 128'(out_valid_r), 128'd1);
      chk("latency", 128'(cyc), 128'(last_e + 2));
      chk("read_pulses", 128'(rd_cnt - rd_base), 128'd8);
      snap0 = pack_rows(1'b0);
      snap1 = pack_rows(1'b1);
      if (hold > 0) begin
         out_ready = 1'b0;
         in_valid  = 1'b1;
         for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_stable", pack_rows(1'b0), snap0);
            chk("hold_valid", 128'(out_valid), 128'd1);
            chk("hold_in_ready", 128'(in_ready), 128'd0);
            chk("hold_no_read", 128'(rd_cnt - rd_base), 128'd8);
         end
         out_ready = 1'b1;
         in_valid  = 1'b0;
      end
      chk("sb_nonempty", 128'(sb.size() > 0), 128'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("rows_relu0", snap0, e.e0);
         chk("rows_relu1", snap1, e.e1);
      end
      n_txn++;
      $display("txn %0d: row0=%h row7=%h relu_row0=%h", n_txn, snap0[15:0], snap0[127:112], snap1[15:0]);
      @(negedge clk);
      chk("out_valid_drop", 128'(out_valid), 128'd0);
      chk("in_ready_after", 128'(in_ready), 128'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      x_in      = '0;
      for (int r = 0; r < 8; r++) wv[r] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_rows", pack_rows(1'b0), 128'd0);
      chk("reset_ctrl", 128'({out_valid, in_ready, busy, buf_read_en}), 128'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // unity dot product
      fill_const(16'h0100, 16'h0100);
      send_block(1'b0, 8);
      recv(0);
      chk("unity_row3", 128'(od0[3]), 128'h0800);

      // round half up: 1 * 0x80 -> 0x0001, 1 * 0x7F -> 0x0000
      fill_rand();
      for (int b = 0; b < 8; b++) begin
         sw[b][0] = (b == 0) ? 16'h0001 : 16'h0000;
         sx[b]    = (b == 0) ? 16'h0080 : 16'h0000;
      end
      send_block(1'b0, 8);
      recv(0);
      chk("round_up_row0", 128'(od0[0]), 128'h0001);
      sx[0] = 16'h007F;
      send_block(1'b0, 8);
      recv(0);
      chk("round_down_row0", 128'(od0[0]), 128'h0000);

      // saturation both ways, plus ReLU on the negative case
      fill_const(16'h7FFF, 16'h7FFF);
      send_block(1'b0, 8);
      recv(0);
      chk("sat_pos_row5", 128'(od0[5]), 128'h7FFF);
      fill_const(16'h8000, 16'h7FFF);
      send_block(1'b0, 8);
      recv(0);
      chk("sat_neg_row2", 128'(od0[2]), 128'h8000);
      chk("sat_neg_relu_row2", 128'(od1[2]), 128'h0000);

      // gaps and backpressure, then an independent block
      fill_rand();
      send_block(1'b1, 8);
      recv(5);
      fill_rand();
      send_block(1'b1, 8);
      recv(0);

      // reset mid-block discards partial sums
      fill_const(16'h7FFF, 16'h7FFF);
      send_block(1'b0, 4);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midreset_rows", pack_rows(1'b0), 128'd0);
      chk("midreset_ctrl", 128'({out_valid, in_ready, busy, buf_read_en}), 128'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      fill_rand();
      send_block(1'b0, 8);
      recv(0);

      chk("sb_drained", 128'(sb.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
